rx_status_monitor: RTL and testbench

RX_STATUS_MONITOR -- requirements
Module: rx_status_monitor

---
 rtl/rx_status_monitor.sv | 171 +++++++++++++++++
 tb/tb_rx_status_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rx_status_monitor.sv
// Receiver status monitor: registered PIPE status, sticky code bits, saturating event counters
// and a windowed link-health FSM. Optional error event log enabled by RX_STATUS_EVENT_LOG_EN.
module rx_status_monitor #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned WINDOW    = 1024,
   parameter int unsigned THRESH    = 8,
   parameter int unsigned LOG_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_valid,
   input  logic [2:0]       rx_status,
   input  logic             clear,
   output logic [2:0]       rx_status_q,
   output logic [7:0]       sticky,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] skp_add_cnt,
   output logic [CNT_W-1:0] skp_rem_cnt,
   output logic [1:0]       link_state,
   output logic             link_fail,
   output logic             evt_valid,
   output logic [2:0]       evt_code,
   output logic [15:0]      evt_time,
   input  logic             evt_ready,
   output logic             evt_overrun
);
   localparam int unsigned WIN_W  = $clog2(WINDOW);
   localparam int unsigned WERR_W = $clog2(THRESH + 1);

   typedef enum logic [1:0] {
      StOk       = 2'b00,
      StDegraded = 2'b01,
      StFail     = 2'b10
   } link_e;

   logic [2:0]       r_status;
   logic [7:0]       r_sticky;
   logic [CNT_W-1:0] r_err_cnt, r_add_cnt, r_rem_cnt;
   logic [WIN_W-1:0] r_win_cnt;
   logic [WERR_W-1:0] r_win_err;
   logic [15:0]      r_timer;
   link_e            r_state, w_state_d;

   logic             w_sample, w_err, w_win_last, w_win_bad, w_win_clean;
   logic [WERR_W-1:0] w_win_err_d;

   // Clear wins over a coincident symbol: it is neither counted nor windowed.
   assign w_sample   = rx_valid & ~clear;
   assign w_err      = w_sample & rx_status[2];
   assign w_win_last = w_sample && (r_win_cnt == WIN_W'(WINDOW - 1));

   // Error tally including the current symbol, so the closing symbol counts in its window.
   always_comb begin
      w_win_err_d = r_win_err;
      if (w_err && (r_win_err != WERR_W'(THRESH))) w_win_err_d = r_win_err + 1'b1;
   end

   assign w_win_bad   = (w_win_err_d >= WERR_W'(THRESH));
   assign w_win_clean = (w_win_err_d == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_status  <= 3'b011;
         r_sticky  <= '0;
         r_err_cnt <= '0;
         r_add_cnt <= '0;
         r_rem_cnt <= '0;
         r_win_cnt <= '0;
         r_win_err <= '0;
         r_timer   <= '0;
      end else begin
         r_timer <= r_timer + 16'd1;
         if (rx_valid) r_status <= rx_status;
         if (clear) begin
            r_sticky  <= '0;
            r_err_cnt <= '0;
            r_add_cnt <= '0;
            r_rem_cnt <= '0;
            r_win_cnt <= '0;
            r_win_err <= '0;
         end else if (rx_valid) begin
            r_sticky[rx_status] <= 1'b1;
            if ((rx_status == 3'b001) && (r_add_cnt != '1)) r_add_cnt <= r_add_cnt + 1'b1;
            if ((rx_status == 3'b010) && (r_rem_cnt != '1)) r_rem_cnt <= r_rem_cnt + 1'b1;
            if (rx_status[2] && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
            r_win_cnt <= r_win_cnt + 1'b1;
            r_win_err <= w_win_last ? '0 : w_win_err_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= StOk;
      else        r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      if (clear) begin
         w_state_d = StOk;
      end else if (w_win_last) begin
         case (r_state)
            StOk:       if (w_win_bad) w_state_d = StDegraded;
            StDegraded: begin
               if (w_win_bad)        w_state_d = StFail;
               else if (w_win_clean) w_state_d = StOk;
            end
            default:    w_state_d = r_state;
         endcase
      end
   end

   assign rx_status_q = r_status;
   assign sticky      = r_sticky;
   assign err_cnt     = r_err_cnt;
   assign skp_add_cnt = r_add_cnt;
   assign skp_rem_cnt = r_rem_cnt;
   assign link_state  = r_state;
   assign link_fail   = (r_state == StFail);

`ifdef RX_STATUS_EVENT_LOG_EN
   localparam int unsigned PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

   logic [18:0]      r_mem [LOG_DEPTH];
   logic [PTR_W-1:0] r_wptr, r_rptr;
   logic [PTR_W:0]   r_count;
   logic             r_overrun;
   logic             w_pop, w_full, w_push;

   assign w_pop  = (r_count != '0) && evt_ready;
   assign w_full = (r_count == (PTR_W + 1)'(LOG_DEPTH));
   // A pop in the same cycle frees the slot the new event needs.
   assign w_push = w_err && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= {rx_status, r_timer};
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_push) r_wptr <= (r_wptr == PTR_W'(LOG_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
         if (w_pop)  r_rptr <= (r_rptr == PTR_W'(LOG_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_err && !w_push) r_overrun <= 1'b1;
      end
   end

   assign evt_valid   = (r_count != '0);
   assign evt_code    = r_mem[r_rptr][18:16];
   assign evt_time    = r_mem[r_rptr][15:0];
   assign evt_overrun = r_overrun;
`else
   logic [31:0] w_unused_log;
   assign w_unused_log = {evt_ready, r_timer, 15'(LOG_DEPTH)};

   assign evt_valid   = 1'b0;
   assign evt_code    = 3'b000;
   assign evt_time    = 16'h0000;
   assign evt_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_rx_status_monitor.sv
// Directed self-checking bench for rx_status_monitor (WINDOW=16, THRESH=2, CNT_W=4, LOG_DEPTH=8).
module tb_rx_status_monitor;
   logic        clk = 1'b0;
   logic        rst_n, rx_valid, clear, evt_ready;
   logic [2:0]  rx_status, rx_status_q, evt_code;
   logic [7:0]  sticky;
   logic [3:0]  err_cnt, skp_add_cnt, skp_rem_cnt;
   logic [1:0]  link_state;
   logic        link_fail, evt_valid, evt_overrun;
   logic [15:0] evt_time;
   logic [15:0] tb_cyc;
   logic [2:0]  exp_code [9];
   logic [15:0] exp_time [9];
   int          n_assert = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   // Reference cycle timer, independent of the design.
   always @(posedge clk) begin
      if (!rst_n) tb_cyc <= 16'd0;
      else        tb_cyc <= tb_cyc + 16'd1;
   end

   rx_status_monitor #(
      .CNT_W    (4),
      .WINDOW   (16),
      .THRESH   (2),
      .LOG_DEPTH(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_valid   (rx_valid),
      .rx_status  (rx_status),
      .clear      (clear),
      .rx_status_q(rx_status_q),
      .sticky     (sticky),
      .err_cnt    (err_cnt),
      .skp_add_cnt(skp_add_cnt),
      .skp_rem_cnt(skp_rem_cnt),
      .link_state (link_state),
      .link_fail  (link_fail),
      .evt_valid  (evt_valid),
      .evt_code   (evt_code),
      .evt_time   (evt_time),
      .evt_ready  (evt_ready),
      .evt_overrun(evt_overrun)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] code);
      rx_valid  = 1'b1;
      rx_status = code;
      step();
      rx_valid  = 1'b0;
   endtask

   task automatic window(input logic [15:0] err_mask);
      for (int i = 0; i < 16; i++) send(err_mask[i] ? 3'b100 : 3'b011);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; rx_valid = 1'b0; rx_status = 3'b000; clear = 1'b0; evt_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      chk("rst_status_q", 32'(rx_status_q), 3);
      chk("rst_sticky", 32'(sticky), 0);
      chk("rst_err", 32'(err_cnt), 0);
      chk("rst_add", 32'(skp_add_cnt), 0);
      chk("rst_rem", 32'(skp_rem_cnt), 0);
      chk("rst_link", 32'(link_state), 0);
      chk("rst_fail", 32'(link_fail), 0);
      chk("rst_evt_valid", 32'(evt_valid), 0);
      chk("rst_overrun", 32'(evt_overrun), 0);

      repeat (5) send(3'b001);
      repeat (3) send(3'b010);
      chk("skp_add", 32'(skp_add_cnt), 5);
      chk("skp_rem", 32'(skp_rem_cnt), 3);
      chk("skp_sticky", 32'(sticky), 'h06);
      chk("skp_link", 32'(link_state), 0);
      chk("skp_status_q", 32'(rx_status_q), 2);

      rx_status = 3'b001;
      step();
      chk("hold_status_q", 32'(rx_status_q), 2);
      chk("hold_add", 32'(skp_add_cnt), 5);

      do_clear();
      chk("clr_add", 32'(skp_add_cnt), 0);
      chk("clr_rem", 32'(skp_rem_cnt), 0);
      chk("clr_sticky", 32'(sticky), 0);

      // Window 1: errors on the first and the 16th symbol.
      send(3'b100);
      repeat (14) send(3'b011);
      chk("w1_before_close", 32'(link_state), 0);
      send(3'b100);
      chk("w1_degraded", 32'(link_state), 1);
      chk("w1_err", 32'(err_cnt), 2);
      chk("w1_fail_low", 32'(link_fail), 0);

      window(16'h0088);
      chk("w2_fail_state", 32'(link_state), 2);
      chk("w2_link_fail", 32'(link_fail), 1);
      chk("w2_err", 32'(err_cnt), 4);

      window(16'h0000);
      chk("w3_fail_hold", 32'(link_state), 2);

      do_clear();
      chk("clr_link", 32'(link_state), 0);
      chk("clr_link_fail", 32'(link_fail), 0);
      chk("clr_err", 32'(err_cnt), 0);

      window(16'h8001);
      chk("w4_degraded", 32'(link_state), 1);
      window(16'h0100);
      chk("w5_deg_hold", 32'(link_state), 1);
      window(16'h0000);
      chk("w6_recover", 32'(link_state), 0);

      rx_valid = 1'b1; rx_status = 3'b101; clear = 1'b1;
      step();
      rx_valid = 1'b0; clear = 1'b0;
      chk("clrpri_err", 32'(err_cnt), 0);
      chk("clrpri_sticky", 32'(sticky), 0);
      chk("clrpri_evt_valid", 32'(evt_valid), 0);

      for (int i = 0; i < 20; i++) send(3'(4 + (i % 4)));
      chk("sat_err", 32'(err_cnt), 15);
      chk("sat_sticky", 32'(sticky), 'hF0);
      chk("sat_link", 32'(link_state), 1);
      step();
      step();
      chk("sat_err_held", 32'(err_cnt), 15);

`ifdef RX_STATUS_EVENT_LOG_EN
      do_clear();
      chk("log_cleared", 32'(evt_valid), 0);
      for (int i = 0; i < 9; i++) begin
         exp_code[i] = 3'(4 + (i % 4));
         exp_time[i] = tb_cyc;
         send(exp_code[i]);
      end
      chk("log_valid", 32'(evt_valid), 1);
      chk("log_overrun", 32'(evt_overrun), 1);
      evt_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("log_code%0d", i), 32'(evt_code), 32'(exp_code[i]));
         chk($sformatf("log_time%0d", i), 32'(evt_time), 32'(exp_time[i]));
         step();
      end
      evt_ready = 1'b0;
      chk("log_drained", 32'(evt_valid), 0);
      chk("log_overrun_sticky", 32'(evt_overrun), 1);
`else
      chk("nolog_valid", 32'(evt_valid), 0);
      chk("nolog_overrun", 32'(evt_overrun), 0);
      chk("nolog_code", 32'(evt_code), 0);
      chk("nolog_time", 32'(evt_time), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
